weight_stdp_updater: RTL and testbench

//   Read-modify-write engine that drives the weight RAM's read (addr_r/data_r) and write
//   (addr_w/data_w/we) ports. It is the initiator side of that RAM interface.
//   On a start pulse it sweeps all M synapses of one output neuron once:
//   - reads each weight;
//   - applies an STDP step chosen by the latched presynaptic history bit;
//   - saturates the result;
//   - writes it back.

---
 rtl/weight_stdp_updater.sv | 111 +++++++++++
 tb/tb_weight_stdp_updater.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/weight_stdp_updater.sv
// weight_stdp_updater
//   Read-modify-write sweep over the M synapse weights of one output neuron.
//   A start pulse latches the presynaptic history, then every weight is read,
//   nudged by PRES (history bit set) or PMIN (history bit clear), clamped to
//   [WMIN, WMAX] and written back. One address per cycle; reads run two cycles
//   ahead of writes.
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle sweep request, ignored unless idle
//   pre_hist[M]       presynaptic history, sampled only when start is accepted
//   addr_r, data_r    weight RAM read port (data one cycle after address)
//   addr_w, data_w,
//   we                weight RAM write port (registered)
//   busy              sweep in progress (low again in the done cycle)
//   done              one-cycle pulse after the last write has been issued
module weight_stdp_updater #(
  parameter int M = 784,
  parameter int W = 24,
  parameter logic signed [W-1:0] PRES = 10,
  parameter logic signed [W-1:0] PMIN = -10,
  parameter logic signed [W-1:0] WMAX = 16*4096,
  parameter logic signed [W-1:0] WMIN = -16*4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [M-1:0]        pre_hist,
  output logic [9:0]          addr_r,
  input  logic signed [W-1:0] data_r,
  output logic [9:0]          addr_w,
  output logic signed [W-1:0] data_w,
  output logic                we,
  output logic                busy,
  output logic                done
);

  localparam int AW = 10;
  localparam logic [AW-1:0] LAST = AW'(M-1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  // Bounds widened once so the clamp compares in the W+1 bit sum domain.
  localparam logic signed [W:0] WMAX_X = $signed({WMAX[W-1], WMAX});
  localparam logic signed [W:0] WMIN_X = $signed({WMIN[W-1], WMIN});

  logic [1:0]    state;
  logic [M-1:0]  hist_q;
  logic          drain_cnt;
  // vld_pipe[0]: a read address was presented last cycle, data_r is live now.
  // vld_pipe[1]: the write for that address is on the RAM port (drives we).
  logic [1:0]    vld_pipe;
  logic [AW-1:0] s1_addr;     // address whose data is on data_r this cycle

  logic signed [W-1:0] inc;
  logic signed [W:0]   sum;
  logic signed [W-1:0] sat;

  always_comb begin
    inc = hist_q[s1_addr] ? PRES : PMIN;
    sum = $signed({data_r[W-1], data_r}) + $signed({inc[W-1], inc});
    if (sum > WMAX_X)      sat = WMAX;
    else if (sum < WMIN_X) sat = WMIN;
    else                   sat = sum[W-1:0];
  end

  assign we   = vld_pipe[1];
  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_FIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hist_q    <= '0;
      drain_cnt <= 1'b0;
      vld_pipe  <= '0;
      s1_addr   <= '0;
      addr_r    <= '0;
      addr_w    <= '0;
      data_w    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], state == S_RUN};
      s1_addr  <= addr_r;
      if (vld_pipe[0]) begin
        addr_w <= s1_addr;
        data_w <= sat;
      end
      case (state)
        S_IDLE: if (start) begin
          hist_q    <= pre_hist;
          addr_r    <= '0;
          drain_cnt <= 1'b0;
          state     <= S_RUN;
        end
        S_RUN: begin
          if (addr_r == LAST) state  <= S_DRAIN;
          else                addr_r <= addr_r + 1'b1;
        end
        // Two cycles for the last read to reach the write port.
        S_DRAIN: begin
          if (drain_cnt) state     <= S_FIN;
          else           drain_cnt <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stdp_updater.sv
module tb_weight_stdp_updater;
  localparam int M = 784;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [M-1:0]       pre_hist;
  logic [9:0]         addr_r, addr_w;
  logic signed [23:0] data_r, data_w;
  logic               we, busy, done;

  weight_stdp_updater dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pre_hist(pre_hist),
    .addr_r(addr_r), .data_r(data_r), .addr_w(addr_w), .data_w(data_w),
    .we(we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int cyc; } wr_t;

  int n_chk = 0, n_fail = 0;
  int ecnt = 0, start_ecnt = 0;
  int wr_cnt = 0, done_cnt = 0;
  wr_t sb[$];

  logic signed [23:0] ram [M];
  logic signed [23:0] img [M];
  logic               load = 1'b0;
  int                 mdl [M];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int expw(input int w, input bit h);
    int s;
    s = w + (h ? 10 : -10);
    if (s > 65536) s = 65536;
    else if (s < -65536) s = -65536;
    return s;
  endfunction

  // Weight RAM: registered read, write on posedge.
  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (load) ram <= img;
    else begin
      data_r <= ram[addr_r];
      if (we) ram[addr_w] <= data_w;
    end
  end

  // Monitor: pop expected writes, check done timing.
  always @(negedge clk) begin
    wr_t e;
    if (we) begin
      wr_cnt++;
      if (sb.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", addr_w, e.addr);
        chk("wr_data", data_w, e.data);
        chk("wr_cyc", ecnt - start_ecnt, e.cyc);
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_cyc", ecnt - start_ecnt, M + 3);
    end
  end

  task automatic do_load();
    for (int k = 0; k < M; k++) mdl[k] = int'(img[k]);
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // pulse_cyc: cycle of an extra start pulse (0 = none)
  // rst_cyc:   cycle during which rst_n is held low (0 = none)
  task automatic run_sweep(input int pulse_cyc, input int rst_cyc);
    int nwr;
    logic [M-1:0] h;
    @(negedge clk);
    h   = pre_hist;
    nwr = (rst_cyc != 0) ? rst_cyc - 2 : M;
    for (int k = 0; k < M; k++) begin
      wr_t e;
      e.addr = k;
      e.data = expw(mdl[k], h[k]);
      e.cyc  = k + 3;
      sb.push_back(e);
      if (k < nwr) mdl[k] = e.data;
    end
    wr_cnt = 0; done_cnt = 0;
    start = 1'b1;
    start_ecnt = ecnt;
    for (int c = 1; c <= M + 10; c++) begin
      @(negedge clk);
      start = (c == pulse_cyc);
      if (c == pulse_cyc) pre_hist = ~pre_hist;
      if (c == 1) chk("busy_run", busy, 1);
      if (rst_cyc == 0 && c == M + 3) chk("busy_fin", busy, 0);
      if (rst_cyc != 0) begin
        rst_n = (c != rst_cyc);
        if (c > rst_cyc) chk("abort_we", we, 0);
        if (c == rst_cyc + 1) begin
          chk("abort_busy", busy, 0);
          chk("abort_addr_r", addr_r, 0);
        end
      end
    end
    chk("wr_count", wr_cnt, nwr);
    chk("done_count", done_cnt, (rst_cyc != 0) ? 0 : 1);
    sb.delete();
    for (int k = 0; k < M; k++) chk("dump", ram[k], mdl[k]);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pre_hist = '0;
    for (int k = 0; k < M; k++) img[k] = 24'($urandom_range(0, 2000)) - 24'sd1000;

    // Reset with random inputs.
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      for (int k = 0; k < M; k++) pre_hist[k] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr_r", addr_r, 0);
    chk("rst_addr_w", addr_w, 0);
    chk("rst_data_w", data_w, 0);
    start = 1'b0; rst_n = 1'b1;

    // All potentiation from zero.
    for (int k = 0; k < M; k++) img[k] = '0;
    do_load();
    pre_hist = '1;
    run_sweep(0, 0);
    chk("pot_w0", ram[0], 10);
    chk("pot_w783", ram[783], 10);

    // Alternating history plus saturation corners.
    for (int k = 0; k < M; k++) begin
      img[k] = 24'sd100;
      pre_hist[k] = k[0];
    end
    img[5] = 24'sd65531;
    img[6] = -24'sd65533;
    img[7] = 24'sd65536;
    img[8] = -24'sd65536;
    do_load();
    run_sweep(0, 0);
    chk("alt_even", ram[0], 90);
    chk("alt_odd", ram[1], 110);
    chk("sat_hi", ram[5], 65536);
    chk("sat_lo", ram[6], -65536);
    chk("sat_at_max", ram[7], 65536);
    chk("sat_at_min", ram[8], -65536);

    // Random weights, extra start and history change mid-sweep.
    for (int k = 0; k < M; k++) begin
      img[k] = 24'($urandom_range(0, 140000)) - 24'sd70000;
      pre_hist[k] = 1'($urandom_range(0, 1));
    end
    do_load();
    run_sweep(200, 0);

    // Reset mid-sweep.
    for (int k = 0; k < M; k++) pre_hist[k] = 1'($urandom_range(0, 1));
    run_sweep(0, 100);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
